// File: rtl/dm_wait_resp_pkg.sv
// Shared types and constants for the dm_wait_resp data-memory responder.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DM_WORDS = 1024;
  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/dm_wait_resp_if.sv
// Pipeline data-port bundle. With DM_ERR_EN defined the bundle also carries err.
// Handshake: master holds re/we/addr/din/be until ready; ready is a single-cycle
// completion pulse, stall = (re|we) & ~ready, and dout/err are valid while ready=1.
interface dm_wait_resp_if;
  logic        re;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [3:0]  be;
  logic [31:0] dout;
  logic        ready;
  logic        stall;
  logic        busy;
`ifdef DM_ERR_EN
  logic        err;

  modport master (output re, we, addr, din, be, input dout, ready, stall, busy, err);
  modport slave  (input re, we, addr, din, be, output dout, ready, stall, busy, err);
`else
  modport master (output re, we, addr, din, be, input dout, ready, stall, busy);
  modport slave  (input re, we, addr, din, be, output dout, ready, stall, busy);
`endif
endinterface

// File: rtl/dm_wait_resp_bytearray.sv
// Word array with four byte-write lanes; q returns the word as it was before
// the write on the same edge (read-before-write). q is cleared by rst.
module dm_bytearray
  import dm_pkg::*;
#(
  parameter int AW    = 10,
  parameter int WORDS = DM_WORDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          zero,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   q
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // zero forces a zero result for rejected (misaligned) accesses.
  always_ff @(posedge clk) begin
    if (rst)     q <= 32'h0;
    else if (en) q <= zero ? 32'h0 : mem[idx];
  end

endmodule

// File: rtl/dm_wait_resp.sv
// Multi-cycle data-memory responder with LATENCY wait states and a stall output.
// Defining DM_ERR_EN adds misaligned-access detection reported on bus.err.
module dm_wait_resp
  import dm_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int AW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  dm_wait_resp_if.slave bus,
  output state_t        dbg_state
);

  localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 1);
  localparam bit         ONE_CYCLE = (LATENCY == 1);

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [31:0]   din_q;
  logic [3:0]    be_q;
  logic          wr_q;
  logic          mis_q;
  logic          ready_q;
  logic          err_q;

  logic          req;
  logic          mis_live;
  logic          commit;
  logic          use_live;
  logic          wr_c;
  logic          mis_c;
  logic [AW-1:0] idx_c;
  logic [31:0]   din_c;
  logic [3:0]    be_c;
  logic [3:0]    wen;
  logic [31:0]   q;
  logic          unused_addr;

  assign req         = bus.re | bus.we;
  assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0], err_q};

`ifdef DM_ERR_EN
  logic half_ok;
  assign half_ok  = bus.we && !bus.addr[0] && (bus.be == 4'b0011 || bus.be == 4'b1100);
  assign mis_live = (bus.addr[1:0] != 2'b00) && !half_ok && (!bus.we || (bus.be != 4'b0000));
  assign bus.err  = err_q;
`else
  assign mis_live = 1'b0;
`endif

  // With LATENCY==1 the commit edge is also the capture edge, so the live request feeds the array.
  assign use_live = (state == IDLE);
  assign idx_c    = use_live ? bus.addr[AW+1:2] : idx_q;
  assign din_c    = use_live ? bus.din : din_q;
  assign be_c     = use_live ? bus.be : be_q;
  assign wr_c     = use_live ? bus.we : wr_q;
  assign mis_c    = use_live ? mis_live : mis_q;

  assign commit = !rst && ((state == IDLE && req && ONE_CYCLE) || (state == WAIT && cnt == 4'd1));
  assign wen    = (wr_c && !mis_c) ? be_c : 4'b0000;

  dm_bytearray #(
    .AW    (AW),
    .WORDS (1 << AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (commit),
    .zero  (mis_c),
    .wen   (wen),
    .idx   (idx_c),
    .wdata (din_c),
    .q     (q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (req) begin
            idx_q   <= bus.addr[AW+1:2];
            din_q   <= bus.din;
            be_q    <= bus.be;
            wr_q    <= bus.we;
            mis_q   <= mis_live;
            cnt     <= CNT_INIT;
            state   <= ONE_CYCLE ? DONE : WAIT;
            ready_q <= ONE_CYCLE;
            err_q   <= ONE_CYCLE && mis_live;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state   <= DONE;
            ready_q <= 1'b1;
            err_q   <= mis_q;
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout  = q;
  assign bus.ready = ready_q;
  assign bus.stall = req & ~ready_q;
  assign bus.busy  = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_dm_wait_resp.sv
// Directed bench for dm_wait_resp: five instances (LATENCY 2,1,3,15,4) share one driver.
module tb_dm_wait_resp;
  import dm_pkg::*;

  logic        clk;
  logic        rst;
  logic        re;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [3:0]  be;
  int          sel;

  logic        rdy   [5];
  logic        stl   [5];
  logic        bsy   [5];
  logic [31:0] douts [5];
  state_t      st    [5];
`ifdef DM_ERR_EN
  logic        errs  [5];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : (g == 3) ? 15 : 4;
    dm_wait_resp_if bus_if ();
    assign bus_if.re   = (sel == g) ? re : 1'b0;
    assign bus_if.we   = (sel == g) ? we : 1'b0;
    assign bus_if.addr = addr;
    assign bus_if.din  = din;
    assign bus_if.be   = be;
    assign rdy[g]      = bus_if.ready;
    assign stl[g]      = bus_if.stall;
    assign bsy[g]      = bus_if.busy;
    assign douts[g]    = bus_if.dout;
`ifdef DM_ERR_EN
    assign errs[g]     = bus_if.err;
`endif
    dm_wait_resp #(.LATENCY(LAT), .AW(10)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if.slave),
      .dbg_state (st[g])
    );
  end

  function automatic int lat_of(input int d);
    case (d)
      0: return 2;
      1: return 1;
      2: return 3;
      3: return 15;
      default: return 4;
    endcase
  endfunction

  typedef struct {
    int          dut;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  be;
    logic        chk_dout;
    logic [31:0] exp_dout;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int d, input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] dd, input logic [3:0] b, input logic c,
                              input logic [31:0] ed, input logic ee);
    vec_t v;
    v.dut = d; v.re = r; v.we = w; v.addr = a; v.din = dd; v.be = b;
    v.chk_dout = c; v.exp_dout = ed; v.exp_err = ee; v.exp_lat = lat_of(d);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents one request at a negedge, holds it until ready (bounded), then drops it.
  task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] dd, input logic [3:0] b,
                        output logic [31:0] q, output int lat, output int sc,
                        output logic stall_done, output logic e);
    @(negedge clk);
    sel = d; re = r; we = w; addr = a; din = dd; be = b;
    #1;
    lat = 0;
    sc  = 0;
    while (!rdy[d] && lat < 40) begin
      if (stl[d]) sc++;
      @(negedge clk);
      lat++;
    end
    q          = douts[d];
    stall_done = stl[d];
`ifdef DM_ERR_EN
    e = errs[d];
`else
    e = 1'b0;
`endif
    re = 1'b0;
    we = 1'b0;
  endtask

  task automatic back_to_back(input int d, input logic [31:0] a);
    int n;
    int cnt;
    int first;
    int pulses;
    n = lat_of(d);
    @(negedge clk);
    sel = d; re = 1'b1; we = 1'b0; addr = a;
    #1;
    cnt = 0; first = -1; pulses = 0;
    while (cnt < 100) begin
      if (rdy[d]) begin
        pulses++;
        if (pulses == 1) first = cnt;
        if (pulses == 2) break;
      end
      @(negedge clk);
      cnt++;
    end
    re = 1'b0;
    chk($sformatf("b2b_first_lat%0d", n), first, n);
    chk($sformatf("b2b_second_lat%0d", n), cnt, 2 * n + 1);
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("b2b_idle_lat%0d", n), {31'b0, bsy[d]}, 32'd0);
  endtask

  logic [31:0] q;
  int          lat;
  int          sc;
  logic        sd;
  logic        e;

  initial begin
    rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; din = '0; be = '0; sel = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 5; d++) begin
      chk($sformatf("rst_ready%0d", d), {31'b0, rdy[d]}, 32'd0);
      chk($sformatf("rst_busy%0d", d), {31'b0, bsy[d]}, 32'd0);
      chk($sformatf("rst_stall%0d", d), {31'b0, stl[d]}, 32'd0);
      chk($sformatf("rst_dout%0d", d), douts[d], 32'd0);
      chk($sformatf("rst_state%0d", d), 32'(st[d]), 32'(IDLE));
`ifdef DM_ERR_EN
      chk($sformatf("rst_err%0d", d), {31'b0, errs[d]}, 32'd0);
`endif
    end

    vecs.push_back(mk(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, BE_ALL, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0000_0010, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0020, 32'h1122_3344, BE_ALL, 0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 1, 32'h1122_3344, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0000_0020, 32'h0, 4'h0, 1, 32'h11BB_33DD, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_1004, 32'h5A5A_5A5A, BE_ALL, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0000_0004, 32'h0, 4'h0, 1, 32'h5A5A_5A5A, 0));
    vecs.push_back(mk(0, 1, 1, 32'h0000_0004, 32'h0, BE_ALL, 1, 32'h5A5A_5A5A, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0000_0004, 32'hFFFF_FFFF, 4'h0, 1, 32'h0, 0));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0030, 32'h1234_5678, BE_ALL, 0, 32'h0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0000_0030, 32'h0, 4'h0, 1, 32'h1234_5678, 0));
    vecs.push_back(mk(2, 0, 1, 32'h0000_0034, 32'h0BAD_F00D, BE_ALL, 0, 32'h0, 0));
    vecs.push_back(mk(2, 1, 0, 32'h0000_0034, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 0));
    vecs.push_back(mk(3, 0, 1, 32'h0000_0038, 32'h8765_4321, BE_ALL, 0, 32'h0, 0));
    vecs.push_back(mk(3, 1, 0, 32'h0000_0038, 32'h0, 4'h0, 1, 32'h8765_4321, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0040, 32'h0102_0304, BE_ALL, 0, 32'h0, 0));
`ifdef DM_ERR_EN
    vecs.push_back(mk(0, 1, 0, 32'h0000_0013, 32'h0, 4'h0, 1, 32'h0, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0000_0042, 32'h0, 4'h0, 1, 32'h0, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0041, 32'hFFFF_FFFF, BE_ALL, 1, 32'h0, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0000_0040, 32'h0, 4'h0, 1, 32'h0102_0304, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0042, 32'hAABB_0000, 4'b1100, 1, 32'h0102_0304, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0000_0040, 32'h0, 4'h0, 1, 32'hAABB_0304, 0));
`else
    vecs.push_back(mk(0, 1, 0, 32'h0000_0013, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0000_0042, 32'h0, 4'h0, 1, 32'h0102_0304, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0041, 32'hFFFF_FFFF, BE_ALL, 1, 32'h0102_0304, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0000_0040, 32'h0, 4'h0, 1, 32'hFFFF_FFFF, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0042, 32'hAABB_0000, 4'b1100, 1, 32'hFFFF_FFFF, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0000_0040, 32'h0, 4'h0, 1, 32'hAABB_FFFF, 0));
`endif

    foreach (vecs[i]) begin
      access(vecs[i].dut, vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].be,
             q, lat, sc, sd, e);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_stall_cycles", i), sc, vecs[i].exp_lat);
      chk($sformatf("v%0d_stall_in_done", i), {31'b0, sd}, 32'd0);
      if (vecs[i].chk_dout) chk($sformatf("v%0d_dout", i), q, vecs[i].exp_dout);
`ifdef DM_ERR_EN
      chk($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
`endif
      @(negedge clk);
      chk($sformatf("v%0d_ready_drop", i), {31'b0, rdy[vecs[i].dut]}, 32'd0);
      chk($sformatf("v%0d_busy_drop", i), {31'b0, bsy[vecs[i].dut]}, 32'd0);
    end

    back_to_back(1, 32'h0000_0030);
    back_to_back(2, 32'h0000_0034);
    back_to_back(3, 32'h0000_0038);

    // Request withdrawn in WAIT, with the address changed: access still completes on the captured address.
    @(negedge clk);
    sel = 0; re = 1'b1; we = 1'b0; addr = 32'h0000_0010;
    @(negedge clk);
    re = 1'b0; addr = 32'h0000_0020;
    #1;
    chk("withdraw_stall", {31'b0, stl[0]}, 32'd0);
    chk("withdraw_busy", {31'b0, bsy[0]}, 32'd1);
    chk("withdraw_ready_early", {31'b0, rdy[0]}, 32'd0);
    @(negedge clk);
    chk("withdraw_ready", {31'b0, rdy[0]}, 32'd1);
    chk("withdraw_dout", douts[0], 32'hDEAD_BEEF);
    @(negedge clk);
    chk("withdraw_ready_drop", {31'b0, rdy[0]}, 32'd0);

    // Reset during WAIT on the LATENCY=4 instance abandons the store.
    access(4, 1'b0, 1'b1, 32'h0000_0040, 32'h1111_1111, BE_ALL, q, lat, sc, sd, e);
    @(negedge clk);
    sel = 4; we = 1'b1; addr = 32'h0000_0040; din = 32'hCAFE_F00D; be = BE_ALL;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_state", 32'(st[4]), 32'(IDLE));
    chk("rstmid_busy", {31'b0, bsy[4]}, 32'd0);
    begin
      int pulses;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
        if (rdy[4]) pulses++;
        @(negedge clk);
      end
      chk("rstmid_no_ready", pulses, 0);
    end
    access(4, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, q, lat, sc, sd, e);
    chk("rstmid_mem_kept", q, 32'h1111_1111);
    chk("rstmid_reload_latency", lat, 4);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
